// File: rtl/mem_stage_hs.sv
// Memory-access stage between execute and write-back: valid/ready on both sides, req/gnt + rvalid data port.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses skip the data port and flag wb_misaligned_o.
module mem_stage_hs #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] PC_INIT   = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h00000013
) (
  input  logic              clock_i,
  input  logic              nreset_i,
  input  logic              xu_valid_i,
  output logic              xu_ready_o,
  input  logic [XLEN-1:0]   xu_pc_i,
  input  logic [31:0]       xu_instr_i,
  input  logic              xu_mem_op_i,
  input  logic              xu_mem_we_i,
  input  logic [1:0]        xu_mem_size_i,
  input  logic              xu_mem_unsigned_i,
  input  logic [XLEN-1:0]   xu_mem_addr_i,
  input  logic [XLEN-1:0]   xu_mem_wdata_i,
  input  logic [4:0]        xu_rd_addr_i,
  input  logic [XLEN-1:0]   xu_rd_data_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [XLEN-1:0]   wb_pc_o,
  output logic [31:0]       wb_instr_o,
  output logic [4:0]        wb_rd_addr_o,
  output logic [XLEN-1:0]   wb_rd_data_o,
  output logic              wb_misaligned_o
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {EMPTY, REQ, RSP, DONE} state_e;

  state_e            state_q, state_d;
  logic              accept;
  logic              trap;
  logic [OFFW-1:0]   xu_off;
  logic [NB-1:0]     size_be;

  logic [XLEN-1:0]   pc_q, rd_data_q, addr_q, wdata_q;
  logic [31:0]       instr_q;
  logic [4:0]        rd_addr_q;
  logic [NB-1:0]     be_q;
  logic [1:0]        size_q;
  logic [OFFW-1:0]   off_q;
  logic              we_q, uns_q;

  logic [XLEN-1:0]        ld_shifted, ld_left, ld_data;
  logic signed [XLEN-1:0] ld_sext;
  logic [6:0]             ld_sh;

  assign xu_off = xu_mem_addr_i[OFFW-1:0];
  assign accept = xu_valid_i && xu_ready_o;

`ifdef MEM_MISALIGN_TRAP_EN
  logic [OFFW-1:0] size_mask;
  logic            misaligned_q;
  assign size_mask       = OFFW'((1 << xu_mem_size_i) - 1);
  assign trap            = xu_mem_op_i && (|(xu_off & size_mask));
  assign wb_misaligned_o = misaligned_q;

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i)   misaligned_q <= 1'b0;
    else if (accept) misaligned_q <= trap;
  end
`else
  assign trap            = 1'b0;
  assign wb_misaligned_o = 1'b0;
`endif

  // Byte mask for the access size before lane shifting; lanes past the word fall off the top.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    size_be = '0;
    case (xu_mem_size_i)
      2'd0:    size_be = NB'(8'h01);
      2'd1:    size_be = NB'(8'h03);
      2'd2:    size_be = NB'(8'h0F);
      default: size_be = NB'(8'hFF);
    endcase
  end

  // Load alignment and extension: shift the lane down, then push the field to the top and back.
  always_comb begin
    ld_shifted = dmem_rdata_i >> {off_q, 3'b000};
    ld_sh      = 7'd0;
    case (size_q)
      2'd0:    ld_sh = 7'(XLEN - 8);
      2'd1:    ld_sh = 7'(XLEN - 16);
      2'd2:    ld_sh = (XLEN > 32) ? 7'(XLEN - 32) : 7'd0;
      default: ld_sh = 7'd0;
    endcase
    ld_left = ld_shifted << ld_sh;
    ld_sext = $signed(ld_left) >>> ld_sh;
    ld_data = uns_q ? (ld_left >> ld_sh) : ld_sext;
  end

  // FSM: state register
  always_ff @(posedge clock_i or negedge nreset_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!nreset_i) state_q <= EMPTY;
    else           state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = (xu_mem_op_i && !trap) ? REQ : DONE;
    end else begin
      case (state_q)
        REQ:     if (dmem_gnt_i)    state_d = we_q ? DONE : RSP;
        RSP:     if (dmem_rvalid_i) state_d = DONE;
        DONE:    if (wb_ready_i)    state_d = EMPTY;
        default: state_d = state_q;
      endcase
    end
  end

  // FSM: outputs; the data-port fields are zero whenever no request is pending.
  always_comb begin
    xu_ready_o   = (state_q == EMPTY) || ((state_q == DONE) && wb_ready_i);
    wb_valid_o   = (state_q == DONE);
    dmem_req_o   = (state_q == REQ);
    dmem_we_o    = dmem_req_o && we_q;
    dmem_addr_o  = dmem_req_o ? addr_q  : '0;
    dmem_be_o    = dmem_req_o ? be_q    : '0;
    dmem_wdata_o = dmem_req_o ? wdata_q : '0;
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      pc_q      <= PC_INIT;
      instr_q   <= NOP_INSTR;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      size_q    <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
    end else if (accept) begin
      pc_q      <= xu_pc_i;
      instr_q   <= xu_instr_i;
      rd_addr_q <= xu_rd_addr_i;
      rd_data_q <= trap ? '0 : xu_rd_data_i;
      addr_q    <= {xu_mem_addr_i[XLEN-1:OFFW], {OFFW{1'b0}}};
      wdata_q   <= xu_mem_wdata_i << {xu_off, 3'b000};
      be_q      <= size_be << xu_off;
      size_q    <= xu_mem_size_i;
      off_q     <= xu_off;
      we_q      <= xu_mem_we_i;
      uns_q     <= xu_mem_unsigned_i;
    end else if ((state_q == RSP) && dmem_rvalid_i) begin
      rd_data_q <= ld_data;
    end
  end

  assign wb_pc_o      = pc_q;
  assign wb_instr_o   = instr_q;
  assign wb_rd_addr_o = rd_addr_q;
  assign wb_rd_data_o = rd_data_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs (XLEN=32): scoreboard of expected write-back results plus direct port checks.
module tb_mem_stage_hs;

  localparam logic [31:0] PC_INIT = 32'h0000_0080;

  logic        clock_i = 1'b0;
  logic        nreset_i;
  logic        xu_valid_i, xu_ready_o;
  logic [31:0] xu_pc_i, xu_instr_i;
  logic        xu_mem_op_i, xu_mem_we_i, xu_mem_unsigned_i;
  logic [1:0]  xu_mem_size_i;
  logic [31:0] xu_mem_addr_i, xu_mem_wdata_i, xu_rd_data_i;
  logic [4:0]  xu_rd_addr_i;
  logic        dmem_req_o, dmem_gnt_i, dmem_we_o, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;
  logic        wb_valid_o, wb_ready_i, wb_misaligned_o;
  logic [31:0] wb_pc_o, wb_instr_o, wb_rd_data_o;
  logic [4:0]  wb_rd_addr_o;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  mem_stage_hs #(.XLEN(32), .PC_INIT(PC_INIT), .NOP_INSTR(32'h00000013)) dut (
    .clock_i(clock_i), .nreset_i(nreset_i),
    .xu_valid_i(xu_valid_i), .xu_ready_o(xu_ready_o),
    .xu_pc_i(xu_pc_i), .xu_instr_i(xu_instr_i),
    .xu_mem_op_i(xu_mem_op_i), .xu_mem_we_i(xu_mem_we_i),
    .xu_mem_size_i(xu_mem_size_i), .xu_mem_unsigned_i(xu_mem_unsigned_i),
    .xu_mem_addr_i(xu_mem_addr_i), .xu_mem_wdata_i(xu_mem_wdata_i),
    .xu_rd_addr_i(xu_rd_addr_i), .xu_rd_data_i(xu_rd_data_i),
    .dmem_req_o(dmem_req_o), .dmem_gnt_i(dmem_gnt_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_pc_o(wb_pc_o), .wb_instr_o(wb_instr_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_rd_data_o(wb_rd_data_o), .wb_misaligned_o(wb_misaligned_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, instr, input logic [4:0] rd,
                      input logic [31:0] data, input logic mis);
    exp_t e;
    e.pc = pc; e.instr = instr; e.rd = rd; e.data = data; e.mis = mis;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] pc, instr, input logic mem, we,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, wdata, input logic [4:0] rd,
                       input logic [31:0] rdd);
    xu_pc_i = pc; xu_instr_i = instr; xu_mem_op_i = mem; xu_mem_we_i = we;
    xu_mem_size_i = size; xu_mem_unsigned_i = uns; xu_mem_addr_i = addr;
    xu_mem_wdata_i = wdata; xu_rd_addr_i = rd; xu_rd_data_i = rdd;
  endtask

  // Raise xu_valid_i until the stage takes it; returns after the accepting edge.
  task automatic accept(output int tries);
    logic ok;
    tries = 0;
    xu_valid_i = 1'b1;
    forever begin
      @(negedge clock_i);
      ok = xu_ready_o;
      step();
      if (ok) break;
      tries++;
      if (tries > 20) begin
        check("accept_timeout", 64'd1, 64'd0);
        break;
      end
    end
    xu_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0) begin
      @(negedge clock_i);
      n++;
      if (n > 20) begin
        check("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
      end
    end
    step();
  endtask

  // Scoreboard side: compare each result on its write-back handshake.
  always @(negedge clock_i) begin
    if (nreset_i && wb_valid_o && wb_ready_i) begin
      if (sb.size() == 0) begin
        check("unexpected_wb", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_pc", 64'(wb_pc_o), 64'(e.pc));
        check("wb_instr", 64'(wb_instr_o), 64'(e.instr));
        check("wb_rd_addr", 64'(wb_rd_addr_o), 64'(e.rd));
        check("wb_rd_data", 64'(wb_rd_data_o), 64'(e.data));
        check("wb_misaligned", 64'(wb_misaligned_o), 64'(e.mis));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    nreset_i = 1'b0; xu_valid_i = 1'b0; wb_ready_i = 1'b1;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    drive('0, '0, 1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0);

    // Reset values
    #12;
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_xu_ready", 64'(xu_ready_o), 64'd1);
    check("rst_req", 64'(dmem_req_o), 64'd0);
    check("rst_we", 64'(dmem_we_o), 64'd0);
    check("rst_be", 64'(dmem_be_o), 64'd0);
    check("rst_addr", 64'(dmem_addr_o), 64'd0);
    check("rst_wdata", 64'(dmem_wdata_o), 64'd0);
    check("rst_pc", 64'(wb_pc_o), 64'(PC_INIT));
    check("rst_instr", 64'(wb_instr_o), 64'h13);
    check("rst_rd_addr", 64'(wb_rd_addr_o), 64'd0);
    check("rst_rd_data", 64'(wb_rd_data_o), 64'd0);
    check("rst_mis", 64'(wb_misaligned_o), 64'd0);
    step();
    nreset_i = 1'b1;
    @(negedge clock_i);
    check("rel_xu_ready", 64'(xu_ready_o), 64'd1);
    check("rel_wb_valid", 64'(wb_valid_o), 64'd0);

    // Non-memory op: result one cycle after accept
    step();
    drive(32'h10, 32'h33, 1'b0, 1'b0, 2'd2, 1'b0, '0, '0, 5'd5, 32'h1234);
    push(32'h10, 32'h33, 5'd5, 32'h1234, 1'b0);
    accept(t);
    @(negedge clock_i);
    check("alu_wb_valid", 64'(wb_valid_o), 64'd1);
    wait_drain();

    // LB signed and unsigned from 0x103
    for (int u = 0; u < 2; u++) begin
      drive(32'h20 + u, 32'h03, 1'b1, 1'b0, 2'd0, u[0], 32'h103, '0, 5'd6, 32'hDEAD);
      push(32'h20 + u, 32'h03, 5'd6, (u == 0) ? 32'hFFFFFF80 : 32'h00000080, 1'b0);
      accept(t);
      @(negedge clock_i);
      check("lb_req", 64'(dmem_req_o), 64'd1);
      check("lb_addr", 64'(dmem_addr_o), 64'h100);
      check("lb_be", 64'(dmem_be_o), 64'h8);
      check("lb_we", 64'(dmem_we_o), 64'd0);
      dmem_gnt_i = 1'b1;
      step();
      dmem_gnt_i = 1'b0;
      dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h80FFFFFF;
      step();
      dmem_rvalid_i = 1'b0;
      wait_drain();
    end

    // SH 0xBEEF to 0x202 with grant withheld 3 cycles
    drive(32'h30, 32'h23, 1'b1, 1'b1, 2'd1, 1'b0, 32'h202, 32'h0000BEEF, 5'd0, 32'h55);
    push(32'h30, 32'h23, 5'd0, 32'h55, 1'b0);
    accept(t);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      check("sh_req", 64'(dmem_req_o), 64'd1);
      check("sh_we", 64'(dmem_we_o), 64'd1);
      check("sh_addr", 64'(dmem_addr_o), 64'h200);
      check("sh_be", 64'(dmem_be_o), 64'hC);
      check("sh_wdata", 64'(dmem_wdata_o), 64'hBEEF0000);
      check("sh_wb_valid", 64'(wb_valid_o), 64'd0);
    end
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    @(negedge clock_i);
    check("sh_done", 64'(wb_valid_o), 64'd1);
    wait_drain();

    // Back-pressure in DONE, then no-bubble handoff
    wb_ready_i = 1'b0;
    drive(32'h40, 32'h93, 1'b0, 1'b0, 2'd2, 1'b0, '0, '0, 5'd7, 32'hAAAA);
    push(32'h40, 32'h93, 5'd7, 32'hAAAA, 1'b0);
    accept(t);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      check("bp_xu_ready", 64'(xu_ready_o), 64'd0);
      check("bp_wb_valid", 64'(wb_valid_o), 64'd1);
      check("bp_pc", 64'(wb_pc_o), 64'h40);
      check("bp_rd_data", 64'(wb_rd_data_o), 64'hAAAA);
    end
    step();
    drive(32'h44, 32'hB3, 1'b0, 1'b0, 2'd2, 1'b0, '0, '0, 5'd8, 32'hBBBB);
    push(32'h44, 32'hB3, 5'd8, 32'hBBBB, 1'b0);
    wb_ready_i = 1'b1;
    accept(t);
    check("b2b_tries", 64'(t), 64'd0);
    @(negedge clock_i);
    check("b2b_wb_valid", 64'(wb_valid_o), 64'd1);
    check("b2b_pc", 64'(wb_pc_o), 64'h44);
    wait_drain();

    // LW to misaligned 0x101
    drive(32'h50, 32'h83, 1'b1, 1'b0, 2'd2, 1'b0, 32'h101, '0, 5'd9, 32'h77);
`ifdef MEM_MISALIGN_TRAP_EN
    push(32'h50, 32'h83, 5'd9, 32'h0, 1'b1);
    accept(t);
    @(negedge clock_i);
    check("mis_no_req", 64'(dmem_req_o), 64'd0);
    check("mis_flag", 64'(wb_misaligned_o), 64'd1);
    wait_drain();
`else
    push(32'h50, 32'h83, 5'd9, 32'h00DDCCBB, 1'b0);
    accept(t);
    @(negedge clock_i);
    check("mis_req", 64'(dmem_req_o), 64'd1);
    check("mis_be", 64'(dmem_be_o), 64'hE);
    check("mis_addr", 64'(dmem_addr_o), 64'h100);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDDCCBBAA;
    step();
    dmem_rvalid_i = 1'b0;
    wait_drain();
`endif

    // Reset while waiting for rvalid; late rvalid must be ignored
    drive(32'h60, 32'h83, 1'b1, 1'b0, 2'd2, 1'b0, 32'h300, '0, 5'd10, 32'h99);
    accept(t);
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    nreset_i = 1'b0;
    #1;
    check("arst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("arst_req", 64'(dmem_req_o), 64'd0);
    check("arst_xu_ready", 64'(xu_ready_o), 64'd1);
    step();
    nreset_i = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    step();
    dmem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock_i);
      check("late_wb_valid", 64'(wb_valid_o), 64'd0);
      check("late_rd_data", 64'(wb_rd_data_o), 64'd0);
    end
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
